// File: rtl/sum_xchg_tx_if.sv
// Bus between a core's psum lanes and the sum-exchange FIFO feeding the peer core.
// The master drives lanes and strobes; the slave returns the FIFO head and status.
interface sum_xchg_tx_if #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int sum_bw  = bw_psum + 4,
    parameter int depth   = 4
);
    localparam int CW = $clog2(depth + 1);

    logic [bw_psum*col-1:0] sfp_in;
    logic                   acc;
    logic                   push;
    logic                   fifo_ext_rd;
    logic [sum_bw-1:0]      sum_out;
    logic                   sum_out_vld;
    logic [CW-1:0]          count;
    logic                   ovf;
    logic                   unf;

    modport master (
        output sfp_in, acc, push, fifo_ext_rd,
        input  sum_out, sum_out_vld, count, ovf, unf
    );

    modport slave (
        input  sfp_in, acc, push, fifo_ext_rd,
        output sum_out, sum_out_vld, count, ovf, unf
    );
endinterface

// File: rtl/sum_xchg_tx.sv
// Accumulates per-cycle lane magnitude sums into a saturating total and queues
// pushed totals in a small first-word-fall-through FIFO read by the peer core.
module sum_xchg_tx #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int sum_bw  = bw_psum + 4,
    parameter int depth   = 4
) (
    input  logic          clk,
    input  logic          reset,
    sum_xchg_tx_if.slave  bus
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [sum_bw-1:0] w_abs [col];
    logic [sum_bw-1:0] w_lane_sum;
    logic [sum_bw:0]   w_add;
    logic [sum_bw-1:0] w_sat;
    logic [sum_bw-1:0] w_push_val;
    logic [sum_bw-1:0] w_head_nxt;
    logic              w_empty, w_full, w_pop, w_wr;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_rd_inc;

    logic [sum_bw-1:0] r_total;
    logic [sum_bw-1:0] r_mem [depth];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [sum_bw-1:0] r_sum_out;
    logic              r_ovf, r_unf;

    // Magnitude fits bw_psum bits unsigned, including the most negative lane value.
    for (genvar k = 0; k < col; k++) begin : g_lane
        logic [bw_psum-1:0] w_lane, w_mag;
        assign w_lane   = bus.sfp_in[bw_psum*k +: bw_psum];
        assign w_mag    = w_lane[bw_psum-1] ? (~w_lane + bw_psum'(1)) : w_lane;
        assign w_abs[k] = {{(sum_bw-bw_psum){1'b0}}, w_mag};
    end

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < col; k++) w_lane_sum = w_lane_sum + w_abs[k];
    end

    assign w_add      = {1'b0, r_total} + {1'b0, w_lane_sum};
    assign w_sat      = w_add[sum_bw] ? '1 : w_add[sum_bw-1:0];
    assign w_push_val = bus.acc ? w_sat : r_total;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(depth));
    assign w_pop       = bus.fifo_ext_rd & ~w_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_wr        = bus.push & (~w_full | bus.fifo_ext_rd);
    assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_pop};
    assign w_rd_inc    = r_rd_ptr + PW'(1);

    // Head register: a write lands at the head only when it becomes the sole entry.
    always_comb begin
        w_head_nxt = r_sum_out;
        if (w_wr && w_count_nxt == CW'(1))
            w_head_nxt = w_push_val;
        else if (w_pop && w_count_nxt != '0)
            w_head_nxt = r_mem[w_rd_inc];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_sum_out <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            if (bus.push)     r_total <= '0;
            else if (bus.acc) r_total <= w_sat;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= w_rd_inc;
            r_count   <= w_count_nxt;
            r_sum_out <= w_head_nxt;
            if (bus.push && w_full && !bus.fifo_ext_rd) r_ovf <= 1'b1;
            if (bus.fifo_ext_rd && w_empty)             r_unf <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_val;
    end

    assign bus.sum_out     = r_sum_out;
    assign bus.sum_out_vld = ~w_empty;
    assign bus.count       = r_count;
    assign bus.ovf         = r_ovf;
    assign bus.unf         = r_unf;
endmodule
